// File: rtl/voice_scheduler_if.sv
// rtl/voice_scheduler_if.sv - note event handshake between the MIDI decoder and the voice scheduler
interface voice_scheduler_if #(
  parameter int NOTE_W = 7
);
  logic              note_valid;
  logic              note_ready;
  logic              note_on;
  logic [NOTE_W-1:0] note_num;

  modport master (output note_valid, output note_on, output note_num, input note_ready);
  modport slave  (input note_valid, input note_on, input note_num, output note_ready);
endinterface

// File: rtl/voice_scheduler.sv
// rtl/voice_scheduler.sv - per-voice pipeline sequencer and MIDI note voice allocator
module voice_scheduler #(
  parameter int NUM_VOICES = 16,
  parameter int NOTE_W     = 7
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  voice_scheduler_if.slave   note_if,
  output logic [7:0]         o_voice_index,
  output logic [1:0]         o_pipeline_state,
  output logic               o_frame_done,
  output logic               o_update_flag,
  output logic               o_update_note_status,
  output logic [7:0]         o_update_voice_index,
  output logic [8:0]         o_active_voices
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_VOICE = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DECIDE, S_ISSUE} alloc_state_t;

  alloc_state_t      state, state_nxt;
  logic [1:0]        phase;
  logic [IDX_W-1:0]  voice_idx;
  logic              ready_en;
  logic              accept;

  logic              ev_on;
  logic [NOTE_W-1:0] ev_num;

  logic [NUM_VOICES-1:0] tbl_valid;
  logic [NOTE_W-1:0]     tbl_note [NUM_VOICES];
  logic [IDX_W-1:0]      steal_ptr;
  logic [8:0]            active_cnt;
  logic [IDX_W-1:0]      upd_idx;
  logic                  upd_status;

  logic              match_hit, free_hit;
  logic [IDX_W-1:0]  match_idx, free_idx;
  logic              dec_issue, dec_alloc, dec_steal, dec_release;
  logic [IDX_W-1:0]  dec_target;

  // Free-running phase/voice sequencer; never stalls for event handling
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      phase     <= 2'd0;
      voice_idx <= '0;
    end else begin
      phase <= phase + 2'd1;
      if (phase == 2'd3) begin
        voice_idx <= (voice_idx == LAST_VOICE) ? '0 : voice_idx + IDX_W'(1);
      end
    end
  end

  // Hold off ready for the first cycle after reset release
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) ready_en <= 1'b0;
    else            ready_en <= 1'b1;
  end

  assign accept = (state == S_IDLE) && ready_en && note_if.note_valid;

  // Capture the accepted note event for the DECIDE cycle
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ev_on  <= 1'b0;
      ev_num <= '0;
    end else if (accept) begin
      ev_on  <= note_if.note_on;
      ev_num <= note_if.note_num;
    end
  end

  // Table search: first valid entry holding the event note, and lowest free entry
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!match_hit && tbl_valid[i] && (tbl_note[i] == ev_num)) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!free_hit && !tbl_valid[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Allocation decision: retrigger, fresh voice, steal, release, or drop
  always_comb begin
    dec_issue   = 1'b1;
    dec_target  = match_idx;
    dec_alloc   = 1'b0;
    dec_steal   = 1'b0;
    dec_release = 1'b0;
    if (ev_on) begin
      if (!match_hit && free_hit) begin
        dec_target = free_idx;
        dec_alloc  = 1'b1;
      end else if (!match_hit) begin
        dec_target = steal_ptr;
        dec_steal  = 1'b1;
      end
    end else begin
      if (match_hit) dec_release = 1'b1;
      else           dec_issue   = 1'b0;
    end
  end

  // Voice table, steal pointer, active count and update target registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tbl_valid  <= '0;
      for (int i = 0; i < NUM_VOICES; i++) tbl_note[i] <= '0;
      steal_ptr  <= '0;
      active_cnt <= 9'd0;
      upd_idx    <= '0;
      upd_status <= 1'b0;
    end else if (state == S_DECIDE) begin
      if (dec_alloc) begin
        tbl_valid[dec_target] <= 1'b1;
        tbl_note[dec_target]  <= ev_num;
        active_cnt            <= active_cnt + 9'd1;
      end
      if (dec_steal) begin
        tbl_note[dec_target] <= ev_num;
        steal_ptr <= (steal_ptr == LAST_VOICE) ? '0 : steal_ptr + IDX_W'(1);
      end
      if (dec_release) begin
        tbl_valid[dec_target] <= 1'b0;
        active_cnt            <= active_cnt - 9'd1;
      end
      if (dec_issue) begin
        upd_idx    <= dec_target;
        upd_status <= ev_on;
      end
    end
  end

  // Allocator state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Allocator next state; the strobe is only released in phase 3 so buffers cleared in phase 2 catch it
  always_comb begin
    state_nxt          = state;
    note_if.note_ready = 1'b0;
    o_update_flag      = 1'b0;
    case (state)
      S_IDLE: begin
        note_if.note_ready = ready_en;
        if (accept) state_nxt = S_DECIDE;
      end
      S_DECIDE: begin
        state_nxt = dec_issue ? S_ISSUE : S_IDLE;
      end
      S_ISSUE: begin
        if (phase == 2'd3) begin
          o_update_flag = 1'b1;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_voice_index        = 8'(voice_idx);
  assign o_pipeline_state     = phase;
  assign o_frame_done         = (phase == 2'd3) && (voice_idx == LAST_VOICE);
  assign o_update_voice_index = 8'(upd_idx);
  assign o_update_note_status = upd_status;
  assign o_active_voices      = active_cnt;

endmodule
